// File: rtl/data_memory_arbiter.sv
// Two-port request/ack arbiter and sequencer for the single-port data memory.
// Alternating priority on ties, registered memory strobes, range-checked access.
module data_memory_arbiter #(
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic                  err0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic                  err1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  mem_WE,
   output logic [ADDR_WIDTH-1:0] mem_A,
   output logic [DATA_WIDTH-1:0] mem_WD,
   input  logic [DATA_WIDTH-1:0] mem_RD,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

   state_t                state;
   logic                  last;
   logic                  gnt;
   logic                  lwe;
   logic                  loor;

   logic                  pick1;
   logic                  s_we;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [DATA_WIDTH-1:0] s_wd;
   logic                  s_oor;
   logic [DATA_WIDTH-1:0] rv;

   // Port 1 wins when alone, or on a tie when port 0 was served last.
   assign pick1  = req1 & (~req0 | ~last);
   assign s_we   = pick1 ? we1 : we0;
   assign s_addr = pick1 ? addr1 : addr0;
   assign s_wd   = pick1 ? wdata1 : wdata0;
   assign s_oor  = {1'b0, s_addr} >= DEPTH;

   // Writes echo their own data; rejected accesses return zero.
   assign rv = loor ? '0 : (lwe ? mem_WD : mem_RD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         last   <= 1'b1;
         gnt    <= 1'b0;
         lwe    <= 1'b0;
         loor   <= 1'b0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         busy   <= 1'b0;
         mem_WE <= 1'b0;
         mem_A  <= '0;
         mem_WD <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  state  <= ACCESS;
                  gnt    <= pick1;
                  last   <= pick1;
                  lwe    <= s_we;
                  loor   <= s_oor;
                  mem_A  <= s_addr;
                  mem_WD <= s_wd;
                  mem_WE <= s_we & ~s_oor;
                  busy   <= 1'b1;
               end
            end
            ACCESS: begin
               if (gnt) rdata1 <= rv;
               else     rdata0 <= rv;
               ack0   <= ~gnt;
               ack1   <= gnt;
               err0   <= ~gnt & loor;
               err1   <= gnt & loor;
               mem_WE <= 1'b0;
               mem_A  <= '0;
               mem_WD <= '0;
               state  <= RESP;
            end
            RESP: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic
// checked against a transaction-level memory model.
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0;
   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [31:0] addr1 = '0, wdata1 = '0;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_WE, busy;
   logic [31:0] mem_A, mem_WD, mem_RD;

   int checks = 0;
   int passed = 0;
   int collide = 0;

   logic [31:0] mem  [1024];
   logic [31:0] refm [1024];
   logic        mlast;

   always #5 clk = ~clk;

   data_memory_arbiter #(
      .MEM_DEPTH (1024),
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .we0   (we0),
      .addr0 (addr0),
      .wdata0(wdata0),
      .ack0  (ack0),
      .err0  (err0),
      .rdata0(rdata0),
      .req1  (req1),
      .we1   (we1),
      .addr1 (addr1),
      .wdata1(wdata1),
      .ack1  (ack1),
      .err1  (err1),
      .rdata1(rdata1),
      .mem_WE(mem_WE),
      .mem_A (mem_A),
      .mem_WD(mem_WD),
      .mem_RD(mem_RD),
      .busy  (busy)
   );

   // Memory environment
   assign mem_RD = (mem_A < 32'd1024) ? mem[mem_A[9:0]] : '0;

   always @(posedge clk)
      if (mem_WE && mem_A < 32'd1024) mem[mem_A[9:0]] <= mem_WD;

   always @(negedge clk)
      if (ack0 && ack1) collide++;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Transaction-level reference: what one completed access returns.
   task automatic mdl(input logic w, input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] er, output logic ee);
      ee = (a >= 32'd1024);
      er = ee ? 32'h0 : (w ? d : refm[a[9:0]]);
      if (!ee && w) refm[a[9:0]] = d;
   endtask

   task automatic do_txn(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
      int n, wen, oth;
      logic got, e, abad, ee;
      logic [31:0] r, er;
      n = 0; wen = 0; oth = 0;
      got = 0; e = 0; abad = 0; r = '0;
      @(negedge clk);
      if (p == 0) begin
         req0 = 1; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1; we1 = w; addr1 = a; wdata1 = d;
      end
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (mem_WE) begin
            wen++;
            if (mem_A !== a || mem_WD !== d) abad = 1;
         end
         if (p == 0) begin
            got = ack0; r = rdata0; e = err0;
            if (ack1) oth++;
         end else begin
            got = ack1; r = rdata1; e = err1;
            if (ack0) oth++;
         end
      end
      req0 = 0; req1 = 0;
      mdl(w, a, d, er, ee);
      mlast = (p != 0);
      chk({tag, "_lat"}, n, 2);
      chk({tag, "_err"}, 32'(e), 32'(ee));
      chk({tag, "_rdata"}, r, er);
      chk({tag, "_wecnt"}, wen, (w && !ee) ? 1 : 0);
      chk({tag, "_otherack"}, oth, 0);
      chk({tag, "_memaddr"}, 32'(abad), 0);
   endtask

   task automatic do_pair(input logic w0, input logic [31:0] a0,
                          input logic [31:0] d0, input logic w1,
                          input logic [31:0] a1, input logic [31:0] d1,
                          input string tag);
      int n, fst, first;
      logic got0, got1, e0, e1, x0, x1;
      logic [31:0] r0, r1, q0, q1;
      n = 0; fst = -1;
      got0 = 0; got1 = 0; e0 = 0; e1 = 0; r0 = '0; r1 = '0;
      first = mlast ? 0 : 1;
      @(negedge clk);
      req0 = 1; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = 1; we1 = w1; addr1 = a1; wdata1 = d1;
      while (!(got0 && got1) && n < 20) begin
         @(negedge clk);
         n++;
         if (ack0 && !got0) begin
            got0 = 1; r0 = rdata0; e0 = err0; req0 = 0;
            if (fst < 0) fst = 0;
         end
         if (ack1 && !got1) begin
            got1 = 1; r1 = rdata1; e1 = err1; req1 = 0;
            if (fst < 0) fst = 1;
         end
      end
      req0 = 0; req1 = 0;
      if (first == 0) begin
         mdl(w0, a0, d0, q0, x0);
         mdl(w1, a1, d1, q1, x1);
      end else begin
         mdl(w1, a1, d1, q1, x1);
         mdl(w0, a0, d0, q0, x0);
      end
      mlast = (first == 0);
      chk({tag, "_order"}, fst, first);
      chk({tag, "_done"}, {30'b0, got1, got0}, 32'h3);
      chk({tag, "_rd0"}, r0, q0);
      chk({tag, "_rd1"}, r1, q1);
      chk({tag, "_err"}, {30'b0, e1, e0}, {30'b0, x1, x0});
   endtask

   function automatic logic [31:0] rnd_addr();
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) return 32'd1024 + $urandom_range(0, 100);
      if (k == 1) return $urandom | 32'h8000_0000;
      return 32'($urandom_range(0, 31));
   endfunction

   initial begin
      int n, spur, a1cnt;
      int ord[$];
      int tn[$];
      for (int i = 0; i < 1024; i++) begin
         mem[i]  = '0;
         refm[i] = '0;
      end
      mlast = 1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_err", {30'b0, err1, err0}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(mem_WE), 0);
      chk("rst_addr", mem_A, 0);
      chk("rst_wd", mem_WD, 0);
      chk("rst_rd0", rdata0, 0);
      chk("rst_rd1", rdata1, 0);
      rst = 1;

      // Write then read, port 0; overwrite then read via port 1
      do_txn(0, 1, 42, 32'h0000_0020, "wr42");
      do_txn(0, 0, 42, 32'h0, "rd42");
      do_txn(0, 1, 42, 32'h0000_0002, "ow42");
      do_txn(1, 0, 42, 32'h0, "p1rd42");

      // Tie after reset: both held, grants alternate
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      rst = 1;
      mlast = 1;
      req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hAAAA_0000;
      req1 = 1; we1 = 1; addr1 = 6; wdata1 = 32'h5555_FFFF;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (ack0) begin ord.push_back(0); tn.push_back(i); end
         if (ack1) begin ord.push_back(1); tn.push_back(i); end
         if (i == 11) begin req0 = 0; req1 = 0; end
      end
      req0 = 0; req1 = 0;
      refm[5] = 32'hAAAA_0000;
      refm[6] = 32'h5555_FFFF;
      mlast = 1;
      chk("tie_count", ord.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ord.size()) begin
            chk($sformatf("tie_port%0d", i), ord[i], i % 2);
            chk($sformatf("tie_time%0d", i), tn[i], 2 + 3 * i);
         end
      end
      do_txn(0, 0, 5, 32'h0, "rd5");
      do_txn(1, 0, 6, 32'h0, "rd6");

      // Out of range and boundary
      do_txn(0, 1, 0, 32'hCAFE_0001, "wr0");
      do_txn(1, 1, 1024, 32'hDEAD_BEEF, "oor");
      do_txn(1, 0, 0, 32'h0, "rd0");
      do_txn(1, 1, 1023, 32'h0BAD_F00D, "wr1023");
      do_txn(0, 0, 1023, 32'h0, "rd1023");
      do_txn(0, 0, 32'hFFFF_FFFF, 32'h0, "oormax");

      // Reset during ACCESS of a write
      do_txn(0, 1, 7, 32'h1111_1111, "wr7");
      @(negedge clk);
      req0 = 1; we0 = 1; addr0 = 7; wdata0 = 32'h1234_5678;
      @(negedge clk);
      chk("midrst_we_before", 32'(mem_WE), 1);
      #2 rst = 0;
      #1;
      chk("midrst_we", 32'(mem_WE), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_acks", {30'b0, ack1, ack0}, 0);
      req0 = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      mlast = 1;
      spur = 0;
      repeat (5) begin
         @(negedge clk);
         if (ack0 || ack1) spur++;
      end
      chk("midrst_noack", spur, 0);
      do_txn(1, 0, 7, 32'h0, "rd7");

      // Request dropped before grant
      @(negedge clk);
      req0 = 1; we0 = 0; addr0 = 42;
      @(negedge clk);
      req1 = 1; we1 = 0; addr1 = 3;
      @(negedge clk);
      req1 = 0;
      chk("drop_ack0", 32'(ack0), 1);
      chk("drop_rd0", rdata0, refm[42]);
      req0 = 0;
      mlast = 0;
      a1cnt = 0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack1) a1cnt++;
         if (busy) n++;
      end
      chk("drop_noack1", a1cnt, 0);
      chk("drop_busy", n, 0);

      // Random traffic against the model
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 2);
         if (k == 2)
            do_pair(1'($urandom), rnd_addr(), $urandom,
                    1'($urandom), rnd_addr(), $urandom,
                    $sformatf("rp%0d", i));
         else
            do_txn(k, 1'($urandom), rnd_addr(), $urandom,
                   $sformatf("rt%0d", i));
      end

      chk("ack_collision", collide, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
